imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_BYTES, default 256: instruction memory size in bytes, power of two, minimum 4.
REQ-002 Parameter NOP_HALT, default 4: consecutive all-zero fetch cycles that trigger halt.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  single-cycle pulse that starts a program load at byte address 0.
REQ-006 wr_valid  input  1  producer has an instruction word on wr_data.
REQ-007 wr_ready  output  1  loader accepts a word this cycle.
REQ-008 wr_data  input  32  instruction word; bits [31:24] go to the lowest byte address.
REQ-009 wr_last  input  1  qualifies wr_data as the final word of the program.
REQ-010 fetch_addr  input  log2(DEPTH_BYTES)  processor byte fetch address.
REQ-011 fetch_instr  output  32  instruction at fetch_addr.
REQ-012 cpu_reset  output  1  active-high reset to the processor core.
REQ-013 halted  output  1  NOP-run halt detected.
REQ-014 load_count  output  log2(DEPTH_BYTES/4)+1  number of words fully written since the last load_start.
REQ-015 overflow_err  output  1  sticky flag: memory filled before wr_last.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WRITE, RUN and HALT.
REQ-017 IDLE: cpu_reset=1, wr_ready=0; load_start -> LOAD with wr_ptr=0, load_count=0, overflow_err=0.
REQ-018 LOAD: wr_ready=1; a handshake (wr_valid&wr_ready) captures wr_data and wr_last into holding registers -> WRITE.
REQ-019 WRITE: wr_ready=0; one byte is written per cycle at wr_ptr, in big-endian order, and wr_ptr increments; the state lasts exactly 4 cycles.
REQ-020 On the 4th WRITE cycle, load_count increments; captured wr_last=1 -> RUN; otherwise -> LOAD.
REQ-021 Sustained throughput SHALL be one word per 5 cycles; wr_valid held during WRITE SHALL NOT cause a duplicate capture.
REQ-022 Full: if the 4th byte lands at DEPTH_BYTES-1 without wr_last, overflow_err is set -> RUN; wr_ptr wraps to 0.
REQ-023 RUN: cpu_reset=0, wr_ready=0.
REQ-024 fetch_instr = {mem[a], mem[a+1], mem[a+2], mem[a+3]} with a=fetch_addr, addresses modulo DEPTH_BYTES, combinational in every state.
REQ-025 RUN: the NOP counter increments on each clock with fetch_instr==0 and clears on any nonzero value.
REQ-026 RUN: when the NOP counter reaches NOP_HALT -> HALT, where cpu_reset=1 and halted=1.
REQ-027 load_start in RUN or HALT -> LOAD: clears halted, the NOP counter, wr_ptr, load_count and overflow_err; memory is retained and overwritten from address 0.
REQ-028 load_start in LOAD or WRITE SHALL be ignored.
REQ-029 load_start in IDLE together with wr_valid SHALL NOT capture the word, because wr_ready=0 that cycle.
REQ-030 cpu_reset SHALL be registered, with no glitches.
REQ-031 cpu_reset SHALL be high in every state except RUN.

Reset
REQ-032 reset SHALL force IDLE immediately without waiting for clk.
REQ-033 reset: cpu_reset=1, wr_ready=0, halted=0, overflow_err=0, load_count=0, wr_ptr=0, NOP counter=0, all memory bytes=0.
REQ-034 reset asserted mid-WRITE SHALL abandon the partial word; after release, a new load_start is required.

Verification
REQ-035 Basic load: load_start, then words 0x200a000a and 0x200c000b (wr_last) -> bytes 0..7 = 20 0a 00 0a 20 0c 00 0b; load_count=2; cpu_reset falls the cycle after the last byte write; fetch_addr=4 -> fetch_instr=0x200c000b.
REQ-036 NOP halt: RUN with fetch_addr=8 on zeroed memory for 4 clocks -> halted=1 and cpu_reset=1 after the 4th edge; with a nonzero word on the 3rd cycle -> no halt.
REQ-037 Backpressure: wr_valid held high continuously across 3 words -> exactly 3 captures, wr_ready high 1 cycle in every 5, load_count=3.
REQ-038 Overflow: 65 words with no wr_last -> overflow_err=1, load_count=64, RUN entered after word 64, word 65 never accepted.
REQ-039 Reset mid-WRITE after 2 bytes -> outputs at reset values; memory all 0; fetch_addr=0 -> fetch_instr=0.
REQ-040 Wrap fetch: DEPTH_BYTES=256, fetch_addr=254 -> fetch_instr={mem[254], mem[255], mem[0], mem[1]}.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: loads a program into a byte-wide instruction memory and
// sequences the processor core's reset around it.
//
// A load starts with a load_start pulse. Words arrive over a valid/ready
// handshake, and each word is written big-endian, one byte per clock, from
// byte address 0. The core is released from reset once the word flagged
// wr_last has been written, or once the memory is full. While the core runs,
// a run of NOP_HALT consecutive all-zero fetches puts it back into reset
// and reports a halt.
//
// Ports:
//   clk, reset     - single clock; asynchronous active-high reset
//   load_start     - pulse that begins a program load at byte address 0
//   wr_valid/ready - word handshake; wr_data[31:24] goes to the lowest address
//   wr_data        - instruction word
//   wr_last        - marks the final word of the program
//   fetch_addr     - processor byte fetch address (wraps modulo DEPTH_BYTES)
//   fetch_instr    - combinational 32-bit instruction at fetch_addr
//   cpu_reset      - registered active-high reset to the core
//   halted         - a NOP-run halt was detected
//   load_count     - words fully written since the last load_start
//   overflow_err   - sticky: memory filled before wr_last was seen
module imem_loader #(
    parameter int DEPTH_BYTES = 256,
    parameter int NOP_HALT    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_start,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [31:0]                    wr_data,
    input  logic                           wr_last,
    input  logic [$clog2(DEPTH_BYTES)-1:0] fetch_addr,
    output logic [31:0]                    fetch_instr,
    output logic                           cpu_reset,
    output logic                           halted,
    output logic [$clog2(DEPTH_BYTES/4):0] load_count,
    output logic                           overflow_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(DEPTH_BYTES / 4) + 1;
    localparam int NW = $clog2(NOP_HALT + 1);

    localparam logic [AW-1:0] ADDR_ONE   = AW'(32'd1);
    localparam logic [AW-1:0] ADDR_TWO   = AW'(32'd2);
    localparam logic [AW-1:0] ADDR_THREE = AW'(32'd3);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH_BYTES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [NW-1:0] NOP_ONE    = NW'(32'd1);
    localparam logic [NW-1:0] NOP_LAST   = NW'(NOP_HALT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [1:0]      byte_cnt_r;
    logic [31:0]     hold_data_r;
    logic            hold_last_r;
    logic [CW-1:0]   load_count_r;
    logic [NW-1:0]   nop_cnt_r;
    logic            wr_ready_r;
    logic            cpu_reset_r;
    logic            halted_r;
    logic            overflow_r;
    logic [7:0]      mem_r [DEPTH_BYTES];
    logic [7:0]      wr_byte_s;
    logic            mem_we_s;

    assign wr_ready     = wr_ready_r;
    assign cpu_reset    = cpu_reset_r;
    assign halted       = halted_r;
    assign load_count   = load_count_r;
    assign overflow_err = overflow_r;

    // Read port: four consecutive bytes, address arithmetic wraps at the memory size.
    assign fetch_instr = {mem_r[fetch_addr],
                          mem_r[fetch_addr + ADDR_ONE],
                          mem_r[fetch_addr + ADDR_TWO],
                          mem_r[fetch_addr + ADDR_THREE]};

    // Select the held word's byte for this WRITE cycle, most significant byte first.
    always_comb begin
        mem_we_s  = (state_r == WRITE);
        wr_byte_s = 8'h00;
        case (byte_cnt_r)
            2'd0:    wr_byte_s = hold_data_r[31:24];
            2'd1:    wr_byte_s = hold_data_r[23:16];
            2'd2:    wr_byte_s = hold_data_r[15:8];
            2'd3:    wr_byte_s = hold_data_r[7:0];
            default: wr_byte_s = 8'h00;
        endcase
    end

    // Instruction memory: cleared by reset, one byte written per WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_r[wr_ptr_r] <= wr_byte_s;
        end
    end

    // Load / run / halt sequencer with all of its outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            byte_cnt_r   <= 2'd0;
            hold_data_r  <= 32'h0000_0000;
            hold_last_r  <= 1'b0;
            load_count_r <= {CW{1'b0}};
            nop_cnt_r    <= {NW{1'b0}};
            wr_ready_r   <= 1'b0;
            cpu_reset_r  <= 1'b1;
            halted_r     <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, RUN, HALT: begin
                    if (load_start) begin
                        // Restart the load from address 0. Memory contents are
                        // kept and are overwritten as the new words arrive.
                        state_r      <= LOAD;
                        wr_ptr_r     <= {AW{1'b0}};
                        load_count_r <= {CW{1'b0}};
                        overflow_r   <= 1'b0;
                        nop_cnt_r    <= {NW{1'b0}};
                        halted_r     <= 1'b0;
                        wr_ready_r   <= 1'b1;
                        cpu_reset_r  <= 1'b1;
                    end else if (state_r == RUN) begin
                        wr_ready_r <= 1'b0;
                        if (fetch_instr == 32'h0000_0000) begin
                            nop_cnt_r <= nop_cnt_r + NOP_ONE;
                            if (nop_cnt_r == NOP_LAST) begin
                                state_r     <= HALT;
                                halted_r    <= 1'b1;
                                cpu_reset_r <= 1'b1;
                            end else begin
                                cpu_reset_r <= 1'b0;
                            end
                        end else begin
                            nop_cnt_r   <= {NW{1'b0}};
                            cpu_reset_r <= 1'b0;
                        end
                    end else begin
                        wr_ready_r  <= 1'b0;
                        cpu_reset_r <= 1'b1;
                    end
                end
                LOAD: begin
                    cpu_reset_r <= 1'b1;
                    if (wr_valid && wr_ready_r) begin
                        hold_data_r <= wr_data;
                        hold_last_r <= wr_last;
                        byte_cnt_r  <= 2'd0;
                        wr_ready_r  <= 1'b0;
                        state_r     <= WRITE;
                    end else begin
                        wr_ready_r <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_ptr_r   <= wr_ptr_r + ADDR_ONE;
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        load_count_r <= load_count_r + CNT_ONE;
                        if (hold_last_r) begin
                            state_r     <= RUN;
                            cpu_reset_r <= 1'b0;
                        end else if (wr_ptr_r == ADDR_LAST) begin
                            // Memory full with no wr_last: run what we have.
                            overflow_r  <= 1'b1;
                            state_r     <= RUN;
                            cpu_reset_r <= 1'b0;
                        end else begin
                            state_r    <= LOAD;
                            wr_ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    wr_ready_r  <= 1'b0;
                    cpu_reset_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader with default parameters.
// A byte-array model of the memory is filled from the words the bench sees
// accepted, and the halt rule is tracked as a count of consecutive zero fetches.
module tb_imem_loader;

    localparam int D  = 256;
    localparam int NH = 4;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_last;
    logic [7:0]  fetch_addr;
    logic [31:0] fetch_instr;
    logic        cpu_reset;
    logic        halted;
    logic [6:0]  load_count;
    logic        overflow_err;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  mem_m [D];
    logic [31:0] wq [$];
    int          aq [$];
    int          acc_cnt;
    int          rdy_cnt;
    int          gap_min;
    int          gap_max;
    int          nop_m;
    bit          halted_m;

    imem_loader #(.DEPTH_BYTES(D), .NOP_HALT(NH)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_reset    (cpu_reset),
        .halted       (halted),
        .load_count   (load_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model_instr(input int a);
        return {mem_m[a % D], mem_m[(a + 1) % D], mem_m[(a + 2) % D], mem_m[(a + 3) % D]};
    endfunction

    task automatic do_reset();
        reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0;
        wr_data = 32'h0; wr_last = 1'b0; fetch_addr = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < D; i++) mem_m[i] = 8'h00;
    endtask

    // Hold wr_valid high, offering words in order; a word counts as accepted
    // when wr_ready was high in the cycle before the rising edge.
    task automatic run_load(input int n, input bit last, input int budget,
                            input bit start, input bit poke);
        int   cyc;
        int   prev;
        logic rdy;
        logic [31:0] w;
        cyc = 0; prev = -1; acc_cnt = 0; rdy_cnt = 0; gap_min = 1000; gap_max = 0;
        while (acc_cnt < n && cyc < budget) begin
            @(negedge clk);
            wr_valid   = 1'b1;
            wr_data    = wq[acc_cnt];
            wr_last    = last && (acc_cnt == n - 1);
            load_start = (start && cyc == 0) || (poke && acc_cnt == 1);
            rdy = wr_ready;
            if (rdy) rdy_cnt++;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                w = wq[acc_cnt];
                for (int j = 0; j < 4; j++) mem_m[(4 * acc_cnt + j) % D] = w[31 - 8 * j -: 8];
                if (prev >= 0) begin
                    if (cyc - prev < gap_min) gap_min = cyc - prev;
                    if (cyc - prev > gap_max) gap_max = cyc - prev;
                end
                prev = cyc;
                acc_cnt++;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0; load_start = 1'b0;
    endtask

    task automatic wait_run(input string name);
        for (int k = 0; k < 12; k++) begin
            if (cpu_reset == 1'b0) break;
            @(negedge clk);
        end
        n_cmp++;
        if (cpu_reset !== 1'b0) begin
            n_bad++; $display("FAIL %s_run_entry: cpu_reset=%b want 0", name, cpu_reset);
        end
    endtask

    // Walk fetch addresses in aq one per clock and compare against the halt model.
    task automatic run_fetch(input string name);
        foreach (aq[k]) begin
            fetch_addr = 8'(aq[k]);
            #1;
            n_cmp++;
            if (fetch_instr !== model_instr(aq[k])) begin
                n_bad++; $display("FAIL %s_fetch[%0d]: got %h want %h", name, aq[k], fetch_instr, model_instr(aq[k]));
            end
            @(posedge clk);
            if (!halted_m) begin
                if (model_instr(aq[k]) == 32'h0) nop_m++; else nop_m = 0;
                if (nop_m >= NH) halted_m = 1'b1;
            end
            @(negedge clk);
            n_cmp++;
            if (halted !== halted_m || cpu_reset !== halted_m) begin
                n_bad++; $display("FAIL %s_halt step %0d: halted=%b cpu_reset=%b want %b", name, k, halted, cpu_reset, halted_m);
            end
        end
    endtask

    task automatic test_reset();
        int a;
        do_reset();
        n_cmp++;
        if ({cpu_reset, wr_ready, halted, overflow_err} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 1000", {cpu_reset, wr_ready, halted, overflow_err});
        end
        n_cmp++;
        if (load_count !== 7'd0) begin
            n_bad++; $display("FAIL reset_load_count: got %0d want 0", load_count);
        end
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(0, D - 1));
            fetch_addr = 8'(a);
            #1;
            n_cmp++;
            if (fetch_instr !== 32'h0) begin
                n_bad++; $display("FAIL reset_mem[%0d]: got %h want 0", a, fetch_instr);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        wq = '{32'h200a000a, 32'h200c000b};
        fetch_addr = 8'd8;
        run_load(2, 1'b1, 40, 1'b1, 1'b0);
        n_cmp++;
        if (acc_cnt !== 2) begin
            n_bad++; $display("FAIL basic_accepts: got %0d want 2", acc_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cpu_reset !== 1'b1) begin
            n_bad++; $display("FAIL basic_cpu_reset_early: got %b want 1", cpu_reset);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cpu_reset !== 1'b0) begin
            n_bad++; $display("FAIL basic_cpu_reset_fall: got %b want 0", cpu_reset);
        end
        n_cmp++;
        if (load_count !== 7'd2) begin
            n_bad++; $display("FAIL basic_load_count: got %0d want 2", load_count);
        end
        fetch_addr = 8'd4; #1;
        n_cmp++;
        if (fetch_instr !== 32'h200c000b) begin
            n_bad++; $display("FAIL basic_fetch4: got %h want 200c000b", fetch_instr);
        end
        fetch_addr = 8'd2; #1;
        n_cmp++;
        if (fetch_instr !== 32'h000a200c) begin
            n_bad++; $display("FAIL basic_fetch2: got %h want 000a200c", fetch_instr);
        end
    endtask

    task automatic test_nop_halt();
        do_reset();
        wq = '{32'h200a000a, 32'h200c000b};
        fetch_addr = 8'd8;
        run_load(2, 1'b1, 40, 1'b1, 1'b0);
        wait_run("nop1");
        nop_m = 0; halted_m = 1'b0;
        aq = '{8, 8, 8, 8};
        run_fetch("nop_zero");
        n_cmp++;
        if (halted !== 1'b1 || cpu_reset !== 1'b1) begin
            n_bad++; $display("FAIL nop_halt_after4: halted=%b cpu_reset=%b want 1 1", halted, cpu_reset);
        end
        // Reload from HALT: halt must clear and the run starts fresh.
        fetch_addr = 8'd8;
        run_load(2, 1'b1, 40, 1'b1, 1'b0);
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++; $display("FAIL reload_halted_clear: got %b want 0", halted);
        end
        wait_run("nop2");
        n_cmp++;
        if (load_count !== 7'd2) begin
            n_bad++; $display("FAIL reload_load_count: got %0d want 2", load_count);
        end
        nop_m = 0; halted_m = 1'b0;
        aq = '{8, 8, 0, 8, 8, 8};
        run_fetch("nop_break");
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++; $display("FAIL nop_no_halt: got %b want 0", halted);
        end
        aq = {};
        for (int i = 0; i < 24; i++) aq.push_back(int'($urandom_range(0, 15)));
        run_fetch("nop_rand");
    endtask

    task automatic test_back_to_back();
        int a;
        do_reset();
        wq = {};
        for (int i = 0; i < 3; i++) wq.push_back($urandom | 32'h0100_0000);
        run_load(3, 1'b1, 60, 1'b1, 1'b1);
        n_cmp++;
        if (acc_cnt !== 3 || rdy_cnt !== 3) begin
            n_bad++; $display("FAIL b2b_captures: accepts=%0d ready_cycles=%0d want 3 3", acc_cnt, rdy_cnt);
        end
        n_cmp++;
        if (gap_min !== 5 || gap_max !== 5) begin
            n_bad++; $display("FAIL b2b_spacing: min=%0d max=%0d want 5 5", gap_min, gap_max);
        end
        wait_run("b2b");
        n_cmp++;
        if (load_count !== 7'd3) begin
            n_bad++; $display("FAIL b2b_load_count: got %0d want 3", load_count);
        end
        for (int i = 0; i < 6; i++) begin
            a = (i < 3) ? 4 * i : int'($urandom_range(0, 13));
            fetch_addr = 8'(a); #1;
            n_cmp++;
            if (fetch_instr !== model_instr(a)) begin
                n_bad++; $display("FAIL b2b_fetch[%0d]: got %h want %h", a, fetch_instr, model_instr(a));
            end
        end
    endtask

    task automatic test_overflow();
        int a;
        do_reset();
        wq = {};
        for (int i = 0; i < 64; i++) wq.push_back($urandom | 32'h0100_0000);
        run_load(64, 1'b1, 64 * 5 + 20, 1'b1, 1'b0);
        wait_run("full_exact");
        n_cmp++;
        if (overflow_err !== 1'b0 || load_count !== 7'd64) begin
            n_bad++; $display("FAIL full_exact: overflow=%b count=%0d want 0 64", overflow_err, load_count);
        end
        wq = {};
        for (int i = 0; i < 65; i++) wq.push_back($urandom | 32'h0100_0000);
        fetch_addr = 8'd0;
        run_load(65, 1'b0, 65 * 5 + 40, 1'b1, 1'b0);
        n_cmp++;
        if (acc_cnt !== 64) begin
            n_bad++; $display("FAIL ovf_accepts: got %0d want 64", acc_cnt);
        end
        n_cmp++;
        if (overflow_err !== 1'b1 || load_count !== 7'd64 || cpu_reset !== 1'b0) begin
            n_bad++; $display("FAIL ovf_flags: overflow=%b count=%0d cpu_reset=%b want 1 64 0", overflow_err, load_count, cpu_reset);
        end
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 254 : (i == 1) ? 255 : int'($urandom_range(0, D - 1));
            fetch_addr = 8'(a); #1;
            n_cmp++;
            if (fetch_instr !== model_instr(a)) begin
                n_bad++; $display("FAIL wrap_fetch[%0d]: got %h want %h", a, fetch_instr, model_instr(a));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit bad_ready;
        fetch_addr = 8'd0;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; wr_valid = 1'b1; wr_data = $urandom | 32'h0100_0000;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < D; i++) mem_m[i] = 8'h00;
        n_cmp++;
        if ({cpu_reset, wr_ready, halted, overflow_err} !== 4'b1000 || load_count !== 7'd0) begin
            n_bad++; $display("FAIL midwrite_outputs: flags=%b count=%0d want 1000 0",
                              {cpu_reset, wr_ready, halted, overflow_err}, load_count);
        end
        for (int a = 0; a < D; a += 4) begin
            fetch_addr = 8'(a); #1;
            n_cmp++;
            if (fetch_instr !== model_instr(a)) begin
                n_bad++; $display("FAIL midwrite_mem[%0d]: got %h want %h", a, fetch_instr, model_instr(a));
            end
        end
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b1; fetch_addr = 8'd0;
        bad_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_ready !== 1'b0) bad_ready = 1'b1;
        end
        n_cmp++;
        if (bad_ready || cpu_reset !== 1'b1 || load_count !== 7'd0) begin
            n_bad++; $display("FAIL midwrite_idle: ready_seen=%b cpu_reset=%b count=%0d want 0 1 0", bad_ready, cpu_reset, load_count);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_basic();
        test_nop_halt();
        test_back_to_back();
        test_overflow();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
